// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default field widths, ALUOp encodings and the
// ID/EX control bundle layout used by the ID/EX pipeline stage.
package cpu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 2;
  localparam int unsigned CNT_W      = 16;

  // ALUOp encodings decoded by the EX-stage ALU control
  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  // Control bundle carried from ID into EX
  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
  } idex_ctrl_t;

  localparam int unsigned CTRL_W = $bits(idex_ctrl_t);

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detector.
// Ports:
//   ex_valid, ex_memread, ex_rd        : instruction currently in EX
//   id_valid, id_rs1, id_rs2,
//   id_uses_rs1, id_uses_rs2           : instruction currently in ID
//   hazard_c                           : ID reads the register a load in EX will write
module load_use_detector #(
  parameter int unsigned ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  output logic              hazard_c
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // A load targeting x0 never produces a value worth waiting for
  assign ex_is_load = ex_valid & ex_memread & (ex_rd != '0);
  assign rs1_match  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_match  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign hazard_c   = ex_is_load & id_valid & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall and EX flush handling.
// Ports:
//   clk_i, rst_i (async, active-low)
//   id_*_i        : decoded instruction, operands, imm and pc from ID
//   ex_flush_i    : taken branch/jump in EX, squash the ID instruction
//   pc_write_o    : combinational, 0 holds the PC this cycle
//   ifid_write_o  : combinational, 0 holds IF/ID this cycle
//   ex_*_o        : registered ID/EX fields (all zero for a bubble)
//   stall_cnt_o   : saturating count of load-use stall cycles
module id_ex_hazard_stage #(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int unsigned ALUOP_W    = cpu_pkg::ALUOP_W,
  parameter int unsigned CNT_W      = cpu_pkg::CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  id_memwrite_i,
  input  logic                  id_memtoreg_i,
  input  logic                  id_alusrc_i,
  input  logic [ALUOP_W-1:0]    id_aluop_i,
  input  logic [DATA_W-1:0]     id_rs1_data_i,
  input  logic [DATA_W-1:0]     id_rs2_data_i,
  input  logic [DATA_W-1:0]     id_imm_i,
  input  logic [DATA_W-1:0]     id_pc_i,
  input  logic                  ex_flush_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ex_valid_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_regwrite_o,
  output logic                  ex_memread_o,
  output logic                  ex_memwrite_o,
  output logic                  ex_memtoreg_o,
  output logic                  ex_alusrc_o,
  output logic [ALUOP_W-1:0]    ex_aluop_o,
  output logic [DATA_W-1:0]     ex_rs1_data_o,
  output logic [DATA_W-1:0]     ex_rs2_data_o,
  output logic [DATA_W-1:0]     ex_imm_o,
  output logic [DATA_W-1:0]     ex_pc_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  logic hazard;
  logic stall;
  logic bubble;

  load_use_detector #(
    .ADDR_W (REG_ADDR_W)
  ) u_detector (
    .ex_valid    (ex_valid_o),
    .ex_memread  (ex_memread_o),
    .ex_rd       (ex_rd_o),
    .id_valid    (id_valid_i),
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .id_uses_rs1 (id_uses_rs1_i),
    .id_uses_rs2 (id_uses_rs2_i),
    .hazard_c    (hazard)
  );

  // Flush wins over hazard: the ID instruction is discarded, so no freeze
  assign stall        = hazard & ~ex_flush_i;
  assign pc_write_o   = ~stall;
  assign ifid_write_o = ~stall;
  assign bubble       = hazard | ex_flush_i | ~id_valid_i;

  // ID/EX register; a bubble clears every field so forwarding sees nothing
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
      ex_regwrite_o <= 1'b0;
      ex_memread_o  <= 1'b0;
      ex_memwrite_o <= 1'b0;
      ex_memtoreg_o <= 1'b0;
      ex_alusrc_o   <= 1'b0;
      ex_aluop_o    <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_pc_o       <= '0;
    end else if (bubble) begin
      ex_valid_o    <= 1'b0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
      ex_regwrite_o <= 1'b0;
      ex_memread_o  <= 1'b0;
      ex_memwrite_o <= 1'b0;
      ex_memtoreg_o <= 1'b0;
      ex_alusrc_o   <= 1'b0;
      ex_aluop_o    <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_pc_o       <= '0;
    end else begin
      ex_valid_o    <= id_valid_i;
      ex_rs1_o      <= id_rs1_i;
      ex_rs2_o      <= id_rs2_i;
      ex_rd_o       <= id_rd_i;
      ex_regwrite_o <= id_regwrite_i;
      ex_memread_o  <= id_memread_i;
      ex_memwrite_o <= id_memwrite_i;
      ex_memtoreg_o <= id_memtoreg_i;
      ex_alusrc_o   <= id_alusrc_i;
      ex_aluop_o    <= id_aluop_i;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_pc_o       <= id_pc_i;
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: directed scenarios with an
// expected-EX scoreboard, plus a CNT_W=2 instance for counter saturation.
module tb_id_ex_hazard_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_t;

  logic        clk;
  logic        rst_n;
  logic        uses1;
  logic        uses2;
  logic        flush;
  ex_t         id;
  ex_t         obs;
  ex_t         obs_sat;
  ex_t         exp_cur;
  logic        pc_write, ifid_write, pc_write_s, ifid_write_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;
  ex_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;

  id_ex_hazard_stage dut (
    .clk_i(clk), .rst_i(rst_n), .id_valid_i(id.valid),
    .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd),
    .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
    .id_regwrite_i(id.regwrite), .id_memread_i(id.memread), .id_memwrite_i(id.memwrite),
    .id_memtoreg_i(id.memtoreg), .id_alusrc_i(id.alusrc), .id_aluop_i(id.aluop),
    .id_rs1_data_i(id.rs1_data), .id_rs2_data_i(id.rs2_data), .id_imm_i(id.imm), .id_pc_i(id.pc),
    .ex_flush_i(flush), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
    .ex_valid_o(obs.valid), .ex_rs1_o(obs.rs1), .ex_rs2_o(obs.rs2), .ex_rd_o(obs.rd),
    .ex_regwrite_o(obs.regwrite), .ex_memread_o(obs.memread), .ex_memwrite_o(obs.memwrite),
    .ex_memtoreg_o(obs.memtoreg), .ex_alusrc_o(obs.alusrc), .ex_aluop_o(obs.aluop),
    .ex_rs1_data_o(obs.rs1_data), .ex_rs2_data_o(obs.rs2_data), .ex_imm_o(obs.imm), .ex_pc_o(obs.pc),
    .stall_cnt_o(cnt)
  );

  id_ex_hazard_stage #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .id_valid_i(id.valid),
    .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd),
    .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
    .id_regwrite_i(id.regwrite), .id_memread_i(id.memread), .id_memwrite_i(id.memwrite),
    .id_memtoreg_i(id.memtoreg), .id_alusrc_i(id.alusrc), .id_aluop_i(id.aluop),
    .id_rs1_data_i(id.rs1_data), .id_rs2_data_i(id.rs2_data), .id_imm_i(id.imm), .id_pc_i(id.pc),
    .ex_flush_i(flush), .pc_write_o(pc_write_s), .ifid_write_o(ifid_write_s),
    .ex_valid_o(obs_sat.valid), .ex_rs1_o(obs_sat.rs1), .ex_rs2_o(obs_sat.rs2), .ex_rd_o(obs_sat.rd),
    .ex_regwrite_o(obs_sat.regwrite), .ex_memread_o(obs_sat.memread), .ex_memwrite_o(obs_sat.memwrite),
    .ex_memtoreg_o(obs_sat.memtoreg), .ex_alusrc_o(obs_sat.alusrc), .ex_aluop_o(obs_sat.aluop),
    .ex_rs1_data_o(obs_sat.rs1_data), .ex_rs2_data_o(obs_sat.rs2_data), .ex_imm_o(obs_sat.imm),
    .ex_pc_o(obs_sat.pc), .stall_cnt_o(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A stall is always followed by a cycle that lets the PC advance
  assert property (@(posedge clk) disable iff (!rst_n) !pc_write |=> pc_write)
    else begin
      errors++;
      $display("FAIL back_to_back_stall: pc_write low on two consecutive edges, required high");
    end

  function automatic ex_t mk(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] rd, input logic rw, input logic mr,
                             input logic mw, input logic m2r, input logic as,
                             input logic [1:0] op, input logic [31:0] pc);
    ex_t f;
    f.valid = v; f.rs1 = r1; f.rs2 = r2; f.rd = rd;
    f.regwrite = rw; f.memread = mr; f.memwrite = mw; f.memtoreg = m2r; f.alusrc = as;
    f.aluop = op;
    f.rs1_data = 32'hA000_0000 | 32'(r1);
    f.rs2_data = 32'hB000_0000 | 32'(r2);
    f.imm = 32'h10 + pc;
    f.pc = pc;
    return f;
  endfunction

  // Instructions used across scenarios
  ex_t pass_i, lw0, use0, lw5, nouse2, add5, lw7, f7, lw5b;

  task automatic set_id(input ex_t f, input logic u1, input logic u2);
    id = f; uses1 = u1; uses2 = u2;
  endtask

  // Advance one edge and fetch the next scoreboard entry
  task automatic tick();
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries, required >= 1");
      exp_cur = '0;
    end else begin
      exp_cur = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    set_id(pass_i, 1'b1, 1'b1);
    #2;
    checks += 6;
    if (obs !== '0) begin errors++; $display("FAIL reset_ex: got %h, required 0", obs); end
    if (obs_sat !== '0) begin errors++; $display("FAIL reset_ex_sat: got %h, required 0", obs_sat); end
    if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d, required 0", cnt); end
    if (cnt_s !== 2'd0) begin errors++; $display("FAIL reset_cnt_sat: got %0d, required 0", cnt_s); end
    if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %b, required 1", pc_write); end
    if (ifid_write !== 1'b1) begin errors++; $display("FAIL reset_ifid_write: got %b, required 1", ifid_write); end
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_hold_ex: got %h, required 0", obs); end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    set_id(pass_i, 1'b1, 1'b1); #1;
    checks++;
    if (pc_write !== 1'b1) begin errors++; $display("FAIL pass_pc_write: got %b, required 1", pc_write); end
    exp_q.push_back(pass_i);
    tick();
    checks += 3;
    if (obs !== exp_cur) begin errors++; $display("FAIL pass_ex: got %h, required %h", obs, exp_cur); end
    if (obs_sat !== exp_cur) begin errors++; $display("FAIL pass_ex_sat: got %h, required %h", obs_sat, exp_cur); end
    if (pc_write !== 1'b1) begin errors++; $display("FAIL pass_pc_write_after: got %b, required 1", pc_write); end
    // Invalid ID slot becomes a bubble even with nonzero fields
    id.valid = 1'b0;
    exp_q.push_back('0);
    tick();
    checks++;
    if (obs !== exp_cur) begin errors++; $display("FAIL invalid_bubble: got %h, required %h", obs, exp_cur); end
  endtask

  task automatic test_no_false_stall();
    set_id(lw0, 1'b1, 1'b0);
    exp_q.push_back(lw0);
    tick();
    checks++;
    if (obs !== exp_cur) begin errors++; $display("FAIL lw_x0_ex: got %h, required %h", obs, exp_cur); end
    set_id(use0, 1'b1, 1'b1); #1;
    checks++;
    if (pc_write !== 1'b1) begin errors++; $display("FAIL x0_no_stall: got %b, required 1", pc_write); end
    exp_q.push_back(use0);
    tick();
    checks += 2;
    if (obs !== exp_cur) begin errors++; $display("FAIL x0_no_bubble: got %h, required %h", obs, exp_cur); end
    if (cnt !== 16'd0) begin errors++; $display("FAIL x0_cnt: got %0d, required 0", cnt); end
    set_id(lw5, 1'b1, 1'b0);
    exp_q.push_back(lw5);
    tick();
    checks++;
    if (obs !== exp_cur) begin errors++; $display("FAIL lw5_ex: got %h, required %h", obs, exp_cur); end
    set_id(nouse2, 1'b1, 1'b0); #1;
    checks++;
    if (pc_write !== 1'b1) begin errors++; $display("FAIL unused_rs2_no_stall: got %b, required 1", pc_write); end
    exp_q.push_back(nouse2);
    tick();
    checks += 2;
    if (obs !== exp_cur) begin errors++; $display("FAIL unused_rs2_no_bubble: got %h, required %h", obs, exp_cur); end
    if (cnt !== 16'd0) begin errors++; $display("FAIL unused_rs2_cnt: got %0d, required 0", cnt); end
  endtask

  task automatic test_load_use();
    set_id(lw5, 1'b1, 1'b0);
    exp_q.push_back(lw5);
    tick();
    checks++;
    if (obs !== exp_cur) begin errors++; $display("FAIL lu_load_ex: got %h, required %h", obs, exp_cur); end
    set_id(add5, 1'b1, 1'b1); #1;
    checks += 2;
    if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write: got %b, required 0", pc_write); end
    if (ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write: got %b, required 0", ifid_write); end
    exp_q.push_back('0);
    tick();
    checks += 5;
    if (obs !== exp_cur) begin errors++; $display("FAIL lu_bubble: got %h, required %h", obs, exp_cur); end
    if (obs.valid !== 1'b0 || obs.rd !== 5'd0 || obs.regwrite !== 1'b0) begin
      errors++; $display("FAIL lu_bubble_fields: got v=%b rd=%0d rw=%b, required 0/0/0", obs.valid, obs.rd, obs.regwrite);
    end
    if (cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d, required 1", cnt); end
    if (cnt_s !== 2'd1) begin errors++; $display("FAIL lu_cnt_sat: got %0d, required 1", cnt_s); end
    if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_release: got %b, required 1", pc_write); end
    exp_q.push_back(add5);
    tick();
    checks += 2;
    if (obs !== exp_cur) begin errors++; $display("FAIL lu_add_enters: got %h, required %h", obs, exp_cur); end
    if (cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold: got %0d, required 1", cnt); end
  endtask

  task automatic test_flush_hazard();
    set_id(lw7, 1'b1, 1'b0);
    exp_q.push_back(lw7);
    tick();
    checks++;
    if (obs !== exp_cur) begin errors++; $display("FAIL fl_load_ex: got %h, required %h", obs, exp_cur); end
    set_id(f7, 1'b0, 1'b1); flush = 1'b1; #1;
    checks += 2;
    if (pc_write !== 1'b1) begin errors++; $display("FAIL fl_pc_write: got %b, required 1", pc_write); end
    if (ifid_write !== 1'b1) begin errors++; $display("FAIL fl_ifid_write: got %b, required 1", ifid_write); end
    exp_q.push_back('0);
    tick();
    flush = 1'b0;
    checks += 2;
    if (obs !== exp_cur) begin errors++; $display("FAIL fl_bubble: got %h, required %h", obs, exp_cur); end
    if (cnt !== 16'd1) begin errors++; $display("FAIL fl_cnt: got %0d, required 1", cnt); end
  endtask

  task automatic test_back_to_back();
    set_id(lw5, 1'b1, 1'b0);
    exp_q.push_back(lw5);
    tick();
    set_id(lw5b, 1'b1, 1'b0); #1;
    checks += 2;
    if (obs !== exp_cur) begin errors++; $display("FAIL b2b_load_ex: got %h, required %h", obs, exp_cur); end
    if (pc_write !== 1'b0) begin errors++; $display("FAIL b2b_stall1: got %b, required 0", pc_write); end
    exp_q.push_back('0);
    tick();
    checks += 2;
    if (obs !== exp_cur) begin errors++; $display("FAIL b2b_bubble1: got %h, required %h", obs, exp_cur); end
    if (pc_write !== 1'b1) begin errors++; $display("FAIL b2b_no_second_stall: got %b, required 1", pc_write); end
    exp_q.push_back(lw5b);
    tick();
    set_id(add5, 1'b1, 1'b1); #1;
    checks += 2;
    if (obs !== exp_cur) begin errors++; $display("FAIL b2b_load2_ex: got %h, required %h", obs, exp_cur); end
    if (pc_write !== 1'b0) begin errors++; $display("FAIL b2b_stall2: got %b, required 0", pc_write); end
    exp_q.push_back('0);
    tick();
    exp_q.push_back(add5);
    tick();
    checks += 3;
    if (obs !== exp_cur) begin errors++; $display("FAIL b2b_add_ex: got %h, required %h", obs, exp_cur); end
    if (cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt: got %0d, required 3", cnt); end
    if (cnt_s !== 2'd3) begin errors++; $display("FAIL b2b_cnt_sat: got %0d, required 3", cnt_s); end
  endtask

  task automatic test_async_reset();
    set_id(lw5, 1'b1, 1'b0);
    exp_q.push_back(lw5);
    tick();
    set_id(add5, 1'b1, 1'b1); #1;
    checks++;
    if (pc_write !== 1'b0) begin errors++; $display("FAIL ar_stall: got %b, required 0", pc_write); end
    rst_n = 1'b0; #1;
    checks += 4;
    if (obs !== '0) begin errors++; $display("FAIL ar_ex_clear: got %h, required 0", obs); end
    if (cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt_clear: got %0d, required 0", cnt); end
    if (cnt_s !== 2'd0) begin errors++; $display("FAIL ar_cnt_sat_clear: got %0d, required 0", cnt_s); end
    if (pc_write !== 1'b1) begin errors++; $display("FAIL ar_pc_write: got %b, required 1", pc_write); end
    #1 rst_n = 1'b1;
    exp_q.push_back(add5);
    tick();
    checks += 2;
    if (obs !== exp_cur) begin errors++; $display("FAIL ar_first_load: got %h, required %h", obs, exp_cur); end
    if (cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt_after: got %0d, required 0", cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_id(lw5, 1'b1, 1'b0);
      exp_q.push_back(lw5);
      tick();
      set_id(add5, 1'b1, 1'b1); #1;
      checks++;
      if (pc_write_s !== 1'b0) begin errors++; $display("FAIL sat_stall_%0d: got %b, required 0", i, pc_write_s); end
      exp_q.push_back('0);
      tick();
      checks++;
      if (obs_sat !== exp_cur) begin errors++; $display("FAIL sat_bubble_%0d: got %h, required %h", i, obs_sat, exp_cur); end
      exp_q.push_back(add5);
      tick();
      checks += 2;
      if (cnt_s !== ((i + 1 > 3) ? 2'd3 : 2'(i + 1))) begin
        errors++; $display("FAIL sat_cnt_%0d: got %0d, required %0d", i, cnt_s, (i + 1 > 3) ? 3 : i + 1);
      end
      if (cnt !== 16'(i + 1)) begin errors++; $display("FAIL sat_wide_cnt_%0d: got %0d, required %0d", i, cnt, i + 1); end
    end
    id.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('0);
      tick();
    end
    checks += 2;
    if (cnt_s !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d, required 3", cnt_s); end
    if (cnt !== 16'd5) begin errors++; $display("FAIL sat_wide_hold: got %0d, required 5", cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pass_i = mk(1'b1, 5'd1, 5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h40);
    pass_i.imm = 32'h10;
    lw0    = mk(1'b1, 5'd1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h44);
    use0   = mk(1'b1, 5'd0, 5'd0,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h48);
    lw5    = mk(1'b1, 5'd2, 5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h4C);
    nouse2 = mk(1'b1, 5'd9, 5'd5,  5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'h50);
    add5   = mk(1'b1, 5'd5, 5'd6,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h54);
    lw7    = mk(1'b1, 5'd3, 5'd0,  5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h58);
    f7     = mk(1'b1, 5'd3, 5'd7,  5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h5C);
    lw5b   = mk(1'b1, 5'd5, 5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h60);
    uses1 = 1'b0; uses2 = 1'b0; flush = 1'b0; id = '0;

    test_reset();
    test_pass_through();
    test_no_false_stall();
    test_load_use();
    test_flush_hazard();
    test_back_to_back();
    test_async_reset();
    test_saturation();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
